// File: rtl/led_cmd_ctrl.sv
// led_cmd_ctrl: byte-command controller for an N-channel LED bank with blink/toggle modes and ack/error replies
module led_cmd_ctrl #(
  parameter int N_CH        = 8,
  parameter int CLK_FREQ    = 103_340_000,
  parameter int BLINK_HZ    = 2,
  parameter int ARG_TIMEOUT = 1_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic [N_CH-1:0] led_out,
  output logic [N_CH-1:0] on_state,
  output logic [N_CH-1:0] blink_state,
  output logic [7:0]      ack_data,
  output logic            ack_valid,
  input  logic            ack_ready,
  output logic [7:0]      err_count
);
  localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int BW   = HALF > 1 ? $clog2(HALF) : 1;
  localparam int TW   = $clog2(ARG_TIMEOUT + 1);
  typedef enum logic {IDLE, ARG} state_t;
  state_t          state, state_nx;
  logic            op_blink, op_blink_nx;
  logic [N_CH-1:0] on_nx, blink_nx, sel;
  logic [BW-1:0]   bcnt;
  logic [TW-1:0]   tcnt;
  logic            phase, accept, is_upper, is_lower, letter_ok, timeout, done, err, wrap;
  logic [7:0]      idx;
  assign rx_ready  = !ack_valid;
  assign accept    = rx_valid && rx_ready;
  assign is_upper  = rx_data >= 8'h41 && rx_data <= 8'h5A;
  assign is_lower  = rx_data >= 8'h61 && rx_data <= 8'h7A;
  assign idx       = rx_data - (is_upper ? 8'h41 : 8'h61);
  assign letter_ok = (is_upper || is_lower) && idx < 8'(N_CH);
  assign wrap      = bcnt == BW'(HALF - 1);
  // A pending ack freezes the timeout so it is reported only after the ack drains
  assign timeout   = state == ARG && !accept && !ack_valid && tcnt == TW'(ARG_TIMEOUT);
  always_comb begin
    led_out = '0;
    sel     = '0;
    for (int i = 0; i < N_CH; i++) begin
      led_out[i] = blink_state[i] ? on_state[i] & phase : on_state[i];
      sel[i]     = letter_ok && idx == 8'(i);
    end
  end
  always_comb begin
    state_nx    = state;
    op_blink_nx = op_blink;
    on_nx       = on_state;
    blink_nx    = blink_state;
    done        = 1'b0;
    err         = 1'b0;
    if (accept && state == IDLE) begin
      if (rx_data == 8'h21 || rx_data == 8'h2A) begin
        state_nx    = ARG;
        op_blink_nx = rx_data == 8'h2A;
      end else if (letter_ok) begin
        done     = 1'b1;
        on_nx    = is_upper ? on_state | sel : on_state & ~sel;
        blink_nx = blink_state & ~sel;
      end else if (rx_data == 8'h60 || rx_data == 8'h7E) begin
        done     = 1'b1;
        on_nx    = rx_data == 8'h7E ? '1 : '0;
        blink_nx = '0;
      end else
        err = 1'b1;
    end else if (accept) begin
      state_nx = IDLE;
      done     = letter_ok;
      err      = !letter_ok;
      on_nx    = !letter_ok ? on_state : op_blink ? on_state | sel : on_state ^ sel;
      blink_nx = letter_ok && op_blink ? blink_state | sel : blink_state;
    end else if (timeout) begin
      state_nx = IDLE;
      err      = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_blink    <= 1'b0;
      on_state    <= '0;
      blink_state <= '0;
      bcnt        <= '0;
      phase       <= 1'b0;
      tcnt        <= '0;
      ack_valid   <= 1'b0;
      ack_data    <= 8'h00;
      err_count   <= 8'h00;
    end else begin
      state       <= state_nx;
      op_blink    <= op_blink_nx;
      on_state    <= on_nx;
      blink_state <= blink_nx;
      bcnt        <= wrap ? '0 : bcnt + 1'b1;
      phase       <= wrap ? ~phase : phase;
      tcnt        <= state == IDLE ? '0 : (!accept && !ack_valid && tcnt != TW'(ARG_TIMEOUT)) ? tcnt + 1'b1 : tcnt;
      ack_valid   <= done || err || (ack_valid && !ack_ready);
      ack_data    <= done ? 8'h2B : err ? 8'h3F : ack_data;
      err_count   <= err && err_count != 8'hFF ? err_count + 1'b1 : err_count;
    end
  end
endmodule

// File: tb/tb_led_cmd_ctrl.sv
// tb_led_cmd_ctrl: randomized and directed checks of led_cmd_ctrl against a command-level reference model
module tb_led_cmd_ctrl;
  logic       clk = 0, reset_n = 0, rx_valid = 0, ack_ready = 1;
  logic [7:0] rx_data = 0;
  logic       rx_ready, ack_valid;
  logic [7:0] led_out, on_state, blink_state, ack_data, err_count;
  int checks = 0, errors = 0, k = 0;
  logic [7:0] m_on, m_blink;
  int m_pend, m_err;

  led_cmd_ctrl #(.N_CH(8), .CLK_FREQ(8), .BLINK_HZ(1), .ARG_TIMEOUT(5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .led_out(led_out), .on_state(on_state), .blink_state(blink_state), .ack_data(ack_data),
    .ack_valid(ack_valid), .ack_ready(ack_ready), .err_count(err_count));

  always #5 clk = ~clk;
  // edges since reset release; blink phase is (k / HALF) mod 2 with HALF = 4
  always @(posedge clk or negedge reset_n) k <= !reset_n ? 0 : k + 1;

  function automatic logic [7:0] exp_led();
    logic ph = ((k / 4) % 2) == 1;
    for (int i = 0; i < 8; i++) exp_led[i] = m_blink[i] ? m_on[i] & ph : m_on[i];
  endfunction

  task automatic model(input logic [7:0] b, output bit has, output logic [7:0] ea);
    int bi = int'(b);
    int idx = (bi >= 65 && bi <= 90) ? bi - 65 : (bi >= 97 && bi <= 122) ? bi - 97 : 99;
    bit ok = idx < 8;
    has = 1; ea = 8'h2B;
    if (m_pend != 0) begin
      if (!ok) ea = 8'h3F;
      else if (m_pend == 1) m_on[idx] = ~m_on[idx];
      else begin m_on[idx] = 1; m_blink[idx] = 1; end
      m_pend = 0;
    end else if (bi == 33 || bi == 42) begin
      m_pend = bi == 33 ? 1 : 2; has = 0;
    end else if (ok) begin
      m_on[idx] = bi < 97; m_blink[idx] = 0;
    end else if (bi == 96) begin
      m_on = 0; m_blink = 0;
    end else if (bi == 126) begin
      m_on = 8'hFF; m_blink = 0;
    end else ea = 8'h3F;
    if (has && ea == 8'h3F && m_err < 255) m_err++;
  endtask

  task automatic do_reset();
    reset_n = 0; rx_valid = 0; ack_ready = 1;
    m_on = 0; m_blink = 0; m_pend = 0; m_err = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic send(input logic [7:0] b);
    int w = 0;
    bit has;
    logic [7:0] ea;
    rx_data = b; rx_valid = 1;
    while (rx_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL send_wait byte=%h rx_ready=%b required 1", b, rx_ready); end
    @(posedge clk);
    model(b, has, ea);
    @(negedge clk);
    rx_valid = 0;
    checks++; if (ack_valid !== has || (has && ack_data !== ea)) begin errors++; $display("FAIL ack byte=%h got valid=%b data=%h required valid=%b data=%h", b, ack_valid, ack_data, has, ea); end
    checks++; if (on_state !== m_on || blink_state !== m_blink) begin errors++; $display("FAIL state byte=%h got on=%h blink=%h required on=%h blink=%h", b, on_state, blink_state, m_on, m_blink); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL err_count byte=%h got %0d required %0d", b, err_count, m_err); end
    checks++; if (led_out !== exp_led()) begin errors++; $display("FAIL led_out byte=%h got %h required %h", b, led_out, exp_led()); end
    checks++; if (rx_ready !== !has) begin errors++; $display("FAIL rx_ready_busy byte=%h got %b required %b", b, rx_ready, !has); end
    if (has && ack_ready) begin
      @(negedge clk);
      checks++; if (ack_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL ack_clear byte=%h got valid=%b rx_ready=%b required 0 1", b, ack_valid, rx_ready); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({on_state, blink_state, led_out, ack_data, err_count} !== 40'h0 || ack_valid !== 1'b0 || rx_ready !== 1'b1)
      begin errors++; $display("FAIL reset got on=%h blink=%h led=%h ack=%b/%h err=%h rdy=%b required zeros rdy=1", on_state, blink_state, led_out, ack_valid, ack_data, err_count, rx_ready); end
  endtask

  task automatic test_basic();
    send("C");
    checks++; if (on_state !== 8'h04) begin errors++; $display("FAIL on_C got %h required 04", on_state); end
    send("a");
    send("c");
    checks++; if (on_state !== 8'h00) begin errors++; $display("FAIL on_c got %h required 00", on_state); end
  endtask

  task automatic test_errors();
    int e0 = m_err;
    send("I"); send("z"); send(8'h00);
    checks++; if (err_count !== 8'(e0 + 3)) begin errors++; $display("FAIL err_delta got %0d required %0d", err_count, e0 + 3); end
    send("~");
    checks++; if (on_state !== 8'hFF || blink_state !== 8'h00) begin errors++; $display("FAIL all_on got on=%h blink=%h required ff 00", on_state, blink_state); end
    send(8'h60);
    send("!"); send("*");
    send("!"); send("J");
  endtask

  task automatic test_toggle();
    send("!"); send("D");
    checks++; if (on_state[3] !== 1'b1) begin errors++; $display("FAIL toggle1 got %b required 1", on_state[3]); end
    send("!"); send("d");
    checks++; if (on_state[3] !== 1'b0) begin errors++; $display("FAIL toggle2 got %b required 0", on_state[3]); end
  endtask

  task automatic test_blink();
    send("*"); send("b");
    checks++; if (on_state[1] !== 1'b1 || blink_state[1] !== 1'b1) begin errors++; $display("FAIL blink_set got on=%b blink=%b required 1 1", on_state[1], blink_state[1]); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (led_out[1] !== (((k / 4) % 2) == 1)) begin errors++; $display("FAIL blink_phase k=%0d got %b required %b", k, led_out[1], ((k / 4) % 2) == 1); end
    end
    send("b");
    checks++; if (led_out[1] !== 1'b0 || blink_state[1] !== 1'b0) begin errors++; $display("FAIL blink_off got led=%b blink=%b required 0 0", led_out[1], blink_state[1]); end
  endtask

  task automatic test_backpressure();
    bit has;
    logic [7:0] ea;
    ack_ready = 0;
    send("A");
    rx_data = "B"; rx_valid = 1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (rx_ready !== 1'b0 || ack_valid !== 1'b1 || ack_data !== 8'h2B || on_state !== m_on)
        begin errors++; $display("FAIL hold got rdy=%b ack=%b/%h on=%h required 0 1/2b %h", rx_ready, ack_valid, ack_data, on_state, m_on); end
    end
    ack_ready = 1;
    @(negedge clk);
    checks++; if (rx_ready !== 1'b1 || ack_valid !== 1'b0 || on_state !== m_on) begin errors++; $display("FAIL release got rdy=%b ack=%b on=%h required 1 0 %h", rx_ready, ack_valid, on_state, m_on); end
    @(posedge clk);
    model("B", has, ea);
    @(negedge clk);
    rx_valid = 0;
    checks++; if (ack_valid !== 1'b1 || ack_data !== ea || on_state !== m_on) begin errors++; $display("FAIL b_accept got ack=%b/%h on=%h required 1/%h %h", ack_valid, ack_data, on_state, ea, m_on); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    send("!");
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checks++; if (ack_valid !== 1'b0) begin errors++; $display("FAIL timeout_early cycle=%0d got ack_valid=%b required 0", i, ack_valid); end
    end
    @(negedge clk);
    m_pend = 0; if (m_err < 255) m_err++;
    checks++; if (ack_valid !== 1'b1 || ack_data !== 8'h3F || err_count !== 8'(m_err))
      begin errors++; $display("FAIL timeout got ack=%b/%h err=%0d required 1/3f %0d", ack_valid, ack_data, err_count, m_err); end
    @(negedge clk);
    send(8'h60);
  endtask

  task automatic test_reset_in_arg();
    send("~"); send("z"); send("*");
    #1 reset_n = 0;
    #1;
    checks++; if ({on_state, blink_state, led_out, ack_data, err_count} !== 40'h0 || ack_valid !== 1'b0 || rx_ready !== 1'b1)
      begin errors++; $display("FAIL reset_arg got on=%h blink=%h led=%h ack=%b/%h err=%h rdy=%b required zeros rdy=1", on_state, blink_state, led_out, ack_valid, ack_data, err_count, rx_ready); end
    do_reset();
    send(8'h60);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0, 1: b = 8'(8'h41 + $urandom_range(0, 11));
        2, 3: b = 8'(8'h61 + $urandom_range(0, 11));
        4:    b = $urandom_range(0, 1) ? 8'h21 : 8'h2A;
        5:    b = $urandom_range(0, 1) ? 8'h60 : 8'h7E;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b);
    end
  endtask

  task automatic test_saturate();
    for (int n = 0; n < 260; n++) send(8'h00);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL saturate got %0d required 255", err_count); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_errors();
    test_toggle();
    test_blink();
    test_backpressure();
    test_timeout();
    test_reset_in_arg();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_cmd_ctrl.md
# led_cmd_ctrl

Byte-command controller for an N-channel LED/status bank, driven by the UART RX byte stream. It replaces the fixed 8-bit letter decoder on the badge. Channel count is parametrised and there are per-channel blink and toggle modes. Every command returns an ack/error byte on a valid/ready channel toward the UART TX path. It sits between the UART core and the top-level LED mux.

## Interface
- N_CH, 8, number of channels, 1..26 (letters 'A'..'Z').
- CLK_FREQ, 103_340_000, clk frequency in Hz.
- BLINK_HZ, 2, blink rate. Half-period HALF = CLK_FREQ/(2*BLINK_HZ) cycles, must be ≥1.
- ARG_TIMEOUT, 1_000_000, maximum cycles to wait for the argument byte of a two-byte command, must be ≥1.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted on a clk edge when rx_valid & rx_ready.
- led_out  out  N_CH  channel drive, 1 = lit.
- on_state  out  N_CH  registered on bits.
- blink_state  out  N_CH  registered blink bits.
- ack_data  out  8  0x2B '+' on success, 0x3F '?' on error.
- ack_valid  out  1  ack pending.
- ack_ready  in  1  ack consumed on an edge when ack_valid & ack_ready.
- err_count  out  8  saturating error counter.

## Operation
- Channel letter index: upper L−'A', lower L−'a'. A letter is valid only if its index < N_CH.
- Single-byte commands:
  - 'A'+i: on[i]=1, blink[i]=0.
  - 'a'+i: on[i]=0, blink[i]=0.
  - '`' (0x60): all on=0, all blink=0.
  - '~' (0x7E): all on=1, all blink=0.
- Two-byte commands (prefix, then a channel letter of either case):
  - '!': on[i] ^= 1, blink[i] unchanged.
  - '*': on[i]=1, blink[i]=1.
- FSM states:
  - IDLE: a prefix goes to ARG and latches the opcode. Any other byte executes or errors, then stays in IDLE.
  - ARG: the next accepted byte executes or errors, then returns to IDLE. After ARG_TIMEOUT cycles with no byte accepted, an error is reported and the FSM returns to IDLE.
- Errors (no state change): out-of-range letter, unknown byte, a prefix received in ARG, timeout.
- A '+' or '?' ack is produced for every completed command and every error. A prefix byte produces no ack.
- err_count increments on each error and saturates at 255.
- led_out[i] = blink[i] ? (on[i] & phase) : on[i].

## Timing
- Reset (async assert, sync-free deassert). Values:
  - on_state=0, blink_state=0, led_out=0.
  - ack_valid=0, ack_data=0x00, err_count=0.
  - FSM=IDLE, phase=0, blink counter=0, timeout counter=0.
  - rx_ready=1.
- rx_ready = !ack_valid. This is combinational from registers and does not depend on rx_valid.
- State updates on the accepting edge. led_out, on_state and blink_state reflect the update in the following cycle.
- ack_valid rises on the edge after the completing byte is accepted. It holds ack_data stable until the ack_ready handshake and clears on that edge.
- Throughput is at most one completed command per 2 cycles with ack_ready tied high. Prefix bytes are accepted back-to-back.
- Blink counter:
  - Free-runs 0..HALF−1.
  - On wrap, phase toggles.
  - With HALF=1, phase toggles every cycle.
- Timeout counter:
  - Clears on entry to ARG.
  - Increments each ARG cycle with no accept.
  - Timeout fires when it reaches ARG_TIMEOUT. The '?' ack then rises on the next edge.
  - While an ack is pending, the counter does not advance; the timeout is reported after the ack clears.
- Reset mid-command (in ARG or with an ack pending) discards the latched opcode and the pending ack.

## Test plan
- After reset, send 'C' then 'a' with N_CH=8 and ack_ready=1 -> on_state=0x04 one cycle after the 'C' accept, ack '+' each time, rx_ready low for exactly 1 cycle per command.
- With N_CH=8, send 'I' then 'z' -> '?' twice, err_count=2, on_state unchanged. Then '~' -> on_state=0xFF, blink=0.
- With CLK_FREQ=8 and BLINK_HZ=1 (HALF=4), send '*','b' -> on[1]=blink[1]=1. led_out[1] toggles every 4 cycles, aligned to counter wrap. Then 'b' -> led_out[1]=0, blink[1]=0.
- Send '!','D' twice -> on[3] goes 1 then 0, one '+' per pair, no ack after the '!' bytes.
- Hold ack_ready=0 after 'A' with rx_valid held high on 'B' -> rx_ready=0, 'B' not consumed. Raise ack_ready -> '+' consumed, 'B' accepted the next cycle.
- With ARG_TIMEOUT=5, send '!' then idle -> '?' ack 6 cycles after the accept, FSM back in IDLE. Separately, assert reset_n=0 while in ARG -> all outputs return to their reset values immediately.
